pcie_x1_top_evt_cnt: RTL and testbench

Slow-domain consumer of the fast-to-slow level synchronizer outputs. Takes WIDTH synchronized level/toggle lines and converts each transition into a one-cycle event pulse. Keeps a saturating per-channel event counter with a sticky overflow flag. Exposes the counters through a four-phase req/ack read port for status/debug logic on the same clock.

---
 rtl/pcie_x1_top_evt_cnt.sv | 101 ++++++++++
 tb/tb_pcie_x1_top_evt_cnt.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/pcie_x1_top_evt_cnt.sv
// pcie_x1_top_evt_cnt: edge-to-pulse converter with saturating per-channel counters and a req/ack read port
module pcie_x1_top_evt_cnt #(
    parameter int WIDTH     = 1,
    parameter int CNT_W     = 16,
    parameter int SEL_W     = 1,
    parameter int EDGE_MODE = 0,
    parameter int CLR_ON_RD = 1
) (
    input  logic             s_clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sync_in,
    input  logic             clr_all,
    output logic [WIDTH-1:0] evt_pulse,
    output logic [WIDTH-1:0] ovf,
    input  logic             rd_req,
    input  logic [SEL_W-1:0] rd_sel,
    output logic             rd_ack,
    output logic [CNT_W-1:0] rd_data,
    output logic             rd_err
);
    typedef enum logic [1:0] {IDLE, RESP, WAIT} state_t;
    state_t state, state_d;
    logic armed;
    logic [WIDTH-1:0] prev, edges, clr_v, ovf_d;
    logic [CNT_W-1:0] cnt [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [SEL_W-1:0] sel_q;
    logic [CNT_W-1:0] sel_cnt;
    logic sel_ok;
    // selects outside the channel range are errors and never alias onto a real channel
    assign sel_ok = int'(sel_q) < WIDTH;
    // edge detection is suppressed until prev has captured one post-reset sample
    always_comb begin
        edges = armed ? (EDGE_MODE != 0 ? sync_in ^ prev : sync_in & ~prev) : '0;
    end
    // next counter/flag values: a clear still keeps a coincident edge as a count of one
    always_comb begin
        sel_cnt = '0;
        clr_v = '0;
        ovf_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (int'(sel_q) == i) sel_cnt = cnt[i];
            clr_v[i] = clr_all | (state == RESP && CLR_ON_RD != 0 && int'(sel_q) == i);
            cnt_d[i] = clr_v[i] ? CNT_W'(edges[i]) :
                       (edges[i] && cnt[i] != '1) ? cnt[i] + CNT_W'(1) : cnt[i];
            ovf_d[i] = !clr_v[i] && (ovf[i] || (edges[i] && cnt[i] == '1));
        end
    end
    // edge history, event pulses and counters
    always_ff @(posedge s_clk) begin
        if (!rst_n) begin
            armed     <= 1'b0;
            prev      <= '0;
            evt_pulse <= '0;
            ovf       <= '0;
            cnt       <= '{default: '0};
        end else begin
            armed     <= 1'b1;
            prev      <= sync_in;
            evt_pulse <= edges;
            ovf       <= ovf_d;
            cnt       <= cnt_d;
        end
    end
    // read FSM state register
    always_ff @(posedge s_clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end
    // read FSM next state: accept only in IDLE, respond once, wait for request release
    always_comb begin
        state_d = state;
        case (state)
            IDLE:    state_d = rd_req ? RESP : IDLE;
            RESP:    state_d = WAIT;
            WAIT:    state_d = rd_req ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end
    // latch the channel select on request acceptance
    always_ff @(posedge s_clk) begin
        if (!rst_n) sel_q <= '0;
        else if (state == IDLE && rd_req) sel_q <= rd_sel;
    end
    // registered response: set in RESP, held through WAIT, cleared on request release
    always_ff @(posedge s_clk) begin
        if (!rst_n) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
            rd_err  <= 1'b0;
        end else if (state == RESP) begin
            rd_ack  <= 1'b1;
            rd_data <= sel_ok ? sel_cnt : '0;
            rd_err  <= !sel_ok;
        end else if (state == WAIT && !rd_req) begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
            rd_err  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_pcie_x1_top_evt_cnt.sv
// tb_pcie_x1_top_evt_cnt: level and toggle instances checked against a behavioural model plus directed literals
module tb_pcie_x1_top_evt_cnt;
    logic s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    logic       rst_n, clr_all, rd_req;
    logic [1:0] sync_in, rd_sel;
    logic [1:0] evt [2];
    logic [1:0] ovf [2];
    logic       ack [2];
    logic       err [2];
    logic [3:0] data [2];

    pcie_x1_top_evt_cnt #(.WIDTH(2), .CNT_W(4), .SEL_W(2), .EDGE_MODE(0), .CLR_ON_RD(1)) u0 (
        .s_clk(s_clk), .rst_n(rst_n), .sync_in(sync_in), .clr_all(clr_all),
        .evt_pulse(evt[0]), .ovf(ovf[0]), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ack(ack[0]), .rd_data(data[0]), .rd_err(err[0]));
    pcie_x1_top_evt_cnt #(.WIDTH(2), .CNT_W(4), .SEL_W(2), .EDGE_MODE(1), .CLR_ON_RD(1)) u1 (
        .s_clk(s_clk), .rst_n(rst_n), .sync_in(sync_in), .clr_all(clr_all),
        .evt_pulse(evt[1]), .ovf(ovf[1]), .rd_req(rd_req), .rd_sel(rd_sel),
        .rd_ack(ack[1]), .rd_data(data[1]), .rd_err(err[1]));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    // behavioural model: per instance m, per channel c; read phase 0 idle, 1 responding, 2 holding
    bit         started = 0;
    int         m_cnt [2][2];
    bit         m_ovf [2][2];
    bit [1:0]   m_prev [2];
    bit         m_armed [2];
    int         phase, sel_l;
    logic [1:0] x_evt [2];
    logic [1:0] x_ovf [2];
    bit         x_ack, x_err;
    int         x_data [2];

    always @(posedge s_clk) begin
        bit [1:0] e;
        bit rd_clr;
        bit clr;
        started = 1;
        rd_clr = 0;
        if (!rst_n) begin
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < 2; c++) begin
                    m_cnt[m][c] = 0;
                    m_ovf[m][c] = 0;
                end
                m_prev[m] = 0; m_armed[m] = 0; x_evt[m] = 0; x_ovf[m] = 0; x_data[m] = 0;
            end
            phase = 0; sel_l = 0; x_ack = 0; x_err = 0;
        end else begin
            case (phase)
                1: begin
                    x_ack = 1;
                    x_err = sel_l > 1;
                    for (int m = 0; m < 2; m++) x_data[m] = (sel_l <= 1) ? m_cnt[m][sel_l] : 0;
                    rd_clr = sel_l <= 1;
                    phase = 2;
                end
                2: if (!rd_req) begin
                    x_ack = 0; x_err = 0; x_data[0] = 0; x_data[1] = 0; phase = 0;
                end
                default: if (rd_req) begin
                    sel_l = int'(rd_sel); phase = 1;
                end
            endcase
            for (int m = 0; m < 2; m++) begin
                e = !m_armed[m] ? 2'b00 : (m == 1) ? (sync_in ^ m_prev[m]) : (sync_in & ~m_prev[m]);
                x_evt[m] = e;
                m_prev[m] = sync_in;
                m_armed[m] = 1;
                for (int c = 0; c < 2; c++) begin
                    clr = clr_all || (rd_clr && sel_l == c);
                    if (clr) begin
                        m_cnt[m][c] = int'(e[c]);
                        m_ovf[m][c] = 0;
                    end else if (e[c]) begin
                        if (m_cnt[m][c] == 15) m_ovf[m][c] = 1;
                        else m_cnt[m][c] = m_cnt[m][c] + 1;
                    end
                end
                x_ovf[m] = {m_ovf[m][1], m_ovf[m][0]};
            end
        end
    end

    // every-cycle comparison of both instances against the model
    always @(negedge s_clk) begin
        if (started) begin
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("evt%0d", m), 32'(evt[m]), 32'(x_evt[m]));
                chk($sformatf("ovf%0d", m), 32'(ovf[m]), 32'(x_ovf[m]));
                chk($sformatf("ack%0d", m), 32'(ack[m]), 32'(x_ack));
                chk($sformatf("err%0d", m), 32'(err[m]), 32'(x_err));
                chk($sformatf("data%0d", m), 32'(data[m]), 32'(x_data[m]));
            end
        end
    end

    task automatic rd(input logic [1:0] s, input int x0, input int x1, input bit xe, input string nm);
        rd_sel = s;
        rd_req = 1'b1;
        @(negedge s_clk);
        chk({nm, "_lat"}, 32'(ack[0]), 0);
        @(negedge s_clk);
        chk({nm, "_ack"}, 32'(ack[0]), 1);
        chk({nm, "_d0"}, 32'(data[0]), 32'(x0));
        chk({nm, "_d1"}, 32'(data[1]), 32'(x1));
        chk({nm, "_err"}, 32'(err[1]), 32'(xe));
        rd_req = 1'b0;
        @(negedge s_clk);
        chk({nm, "_drop"}, 32'(ack[1]), 0);
    endtask

    initial begin
        rst_n = 1'b0; sync_in = 2'b01; clr_all = 1'b0; rd_req = 1'b0; rd_sel = 2'd0;
        repeat (2) @(negedge s_clk);
        chk("rst_ack", 32'(ack[0]), 0);
        chk("rst_evt", 32'(evt[0]), 0);
        chk("rst_ovf", 32'(ovf[1]), 0);
        rst_n = 1'b1;
        @(negedge s_clk);
        chk("arm_evt0", 32'(evt[0]), 0);
        chk("arm_evt1", 32'(evt[1]), 0);
        sync_in[0] = 1'b0;
        @(negedge s_clk);
        chk("fall_m0", 32'(evt[0][0]), 0);
        chk("fall_m1", 32'(evt[1][0]), 1);
        sync_in[0] = 1'b1;
        @(negedge s_clk);
        chk("rise_m0", 32'(evt[0][0]), 1);
        @(negedge s_clk);
        chk("rise_once", 32'(evt[0][0]), 0);
        rd(2'd0, 1, 2, 0, "rd_ch0");
        for (int i = 0; i < 5; i++) begin
            sync_in[1] = ~sync_in[1];
            @(negedge s_clk);
            chk("tog_m1", 32'(evt[1][1]), 1);
        end
        @(negedge s_clk);
        chk("tog_end", 32'(evt[1][1]), 0);
        rd(2'd1, 3, 5, 0, "rd_tog");
        rd(2'd1, 0, 0, 0, "rd_tog_again");
        for (int i = 0; i < 17; i++) begin
            sync_in[0] = 1'b0;
            @(negedge s_clk);
            sync_in[0] = 1'b1;
            @(negedge s_clk);
        end
        chk("sat_ovf0", 32'(ovf[0][0]), 1);
        chk("sat_ovf1", 32'(ovf[1][0]), 1);
        rd(2'd0, 15, 15, 0, "rd_sat");
        chk("sat_ovf_clr", 32'(ovf[0][0]), 0);
        for (int i = 0; i < 7; i++) begin
            sync_in[1] = 1'b0;
            @(negedge s_clk);
            sync_in[1] = 1'b1;
            @(negedge s_clk);
        end
        sync_in[0] = 1'b0;
        @(negedge s_clk);
        sync_in[0] = 1'b1;
        clr_all = 1'b1;
        @(negedge s_clk);
        clr_all = 1'b0;
        chk("clr_evt", 32'(evt[0][0]), 1);
        rd(2'd0, 1, 1, 0, "clr_ch0");
        rd(2'd1, 0, 0, 0, "clr_ch1");
        chk("clr_ovf", 32'(ovf[0]), 0);
        sync_in[1] = 1'b0;
        @(negedge s_clk);
        sync_in[1] = 1'b1;
        @(negedge s_clk);
        rd_sel = 2'd3;
        rd_req = 1'b1;
        @(negedge s_clk);
        chk("bad_lat", 32'(ack[0]), 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge s_clk);
            chk("bad_ack", 32'(ack[0]), 1);
            chk("bad_err", 32'(err[0]), 1);
            chk("bad_data", 32'(data[1]), 0);
        end
        rd_req = 1'b0;
        @(negedge s_clk);
        chk("bad_drop", 32'(ack[0]), 0);
        chk("bad_err_drop", 32'(err[0]), 0);
        rd(2'd1, 1, 2, 0, "bad_kept");
        rd_sel = 2'd0;
        rd_req = 1'b1;
        repeat (2) @(negedge s_clk);
        chk("abort_ack_pre", 32'(ack[0]), 1);
        rst_n = 1'b0;
        @(negedge s_clk);
        chk("abort_ack", 32'(ack[0]), 0);
        rst_n = 1'b1;
        rd_req = 1'b0;
        sync_in[0] = 1'b0;
        @(negedge s_clk);
        chk("rearm_m0", 32'(evt[0][0]), 0);
        chk("rearm_m1", 32'(evt[1][0]), 0);
        sync_in[0] = 1'b1;
        @(negedge s_clk);
        chk("post_arm_m0", 32'(evt[0][0]), 1);
        chk("post_arm_m1", 32'(evt[1][0]), 1);
        for (int i = 0; i < 3000; i++) begin
            sync_in = sync_in ^ (2'($urandom_range(0, 3)) & 2'($urandom_range(0, 3)));
            clr_all = $urandom_range(0, 24) == 0;
            if ($urandom_range(0, 3) == 0) rd_req = ~rd_req;
            rd_sel = 2'($urandom_range(0, 3));
            rst_n = $urandom_range(0, 499) != 0;
            @(negedge s_clk);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
